sdram_rr_arb: RTL

- N-port round-robin arbiter in front of the single SDRAM controller command port.
- Grants one requester at a time and holds ownership until the controller reports completion (rvalid, wvalid or error).
- Routes completion and error only to the owning port.
- Includes a watchdog that ends stuck transactions so one hung port cannot lock out the others.

---
 rtl/sdram_pkg.sv | 7 +
 rtl/sdram_rr_arb_rr_pick.sv | 20 ++
 rtl/sdram_rr_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared state encoding and default widths for the SDRAM front end
package sdram_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} arb_state_t;
    localparam int SDRAM_AW = 24;
    localparam int SDRAM_DW = 32;
    localparam int SDRAM_MW = SDRAM_DW / 8;
endpackage

// File: rtl/sdram_rr_arb_rr_pick.sv
// rr_pick: round-robin picker, first active request at or after ptr, wrapping
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] index
);
    // scan from the farthest offset down so the nearest active port to ptr wins
    always_comb begin
        valid = |req;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N])
                index = IW'((int'(ptr) + k) % N);
        end
    end
endmodule

// File: rtl/sdram_rr_arb.sv
// sdram_rr_arb: round-robin arbiter owning the single SDRAM controller command port
module sdram_rr_arb
    import sdram_pkg::*;
#(
    parameter int N       = 4,
    parameter int AW      = SDRAM_AW,
    parameter int DW      = SDRAM_DW,
    parameter int MW      = DW / 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_rd,
    input  logic [N*MW-1:0]      req_wr,
    input  logic [N*AW-1:0]      req_addr,
    input  logic [N*DW-1:0]      req_wdata,
    output logic [N-1:0]         req_rdy,
    output logic [N-1:0]         req_rvalid,
    output logic [N-1:0]         req_wvalid,
    output logic [N-1:0]         req_error,
    output logic [DW-1:0]        req_rdata,
    output logic                 ctrl_rd,
    output logic [MW-1:0]        ctrl_wr,
    output logic [AW-1:0]        ctrl_addr,
    output logic [DW-1:0]        ctrl_wdata,
    input  logic                 ctrl_rdy,
    input  logic                 ctrl_rvalid,
    input  logic                 ctrl_wvalid,
    input  logic                 ctrl_error,
    input  logic [DW-1:0]        ctrl_rdata,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] count;
    logic [N-1:0]  act;
    logic [N-1:0]  onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic          issue, in_busy, accept, any_done, wd_fire;

    // a port requests when it reads or presents a nonzero byte mask
    always_comb begin
        act = '0;
        for (int i = 0; i < N; i++)
            act[i] = req_rd[i] | (|req_wr[i*MW +: MW]);
    end

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (act),
        .ptr   (ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign issue    = state == ISSUE;
    assign in_busy  = state == BUSY;
    assign onehot   = N'(1) << owner;
    assign accept   = issue & ctrl_rdy & act[owner];
    assign any_done = ctrl_rvalid | ctrl_wvalid | ctrl_error;
    assign wd_fire  = (TIMEOUT != 0) && in_busy && !any_done && count == CW'(TIMEOUT - 1);

    assign busy       = state != IDLE;
    assign timeout    = wd_fire;
    assign req_rdy    = accept ? onehot : '0;
    assign req_rvalid = (in_busy & ctrl_rvalid) ? onehot : '0;
    assign req_wvalid = (in_busy & ctrl_wvalid) ? onehot : '0;
    assign req_error  = ((in_busy & ctrl_error) | wd_fire) ? onehot : '0;
    assign req_rdata  = (in_busy & ctrl_rvalid) ? ctrl_rdata : '0;

    assign ctrl_rd    = issue & req_rd[owner];
    assign ctrl_wr    = issue ? req_wr[int'(owner)*MW +: MW] : '0;
    assign ctrl_addr  = issue ? req_addr[int'(owner)*AW +: AW] : '0;
    assign ctrl_wdata = issue ? req_wdata[int'(owner)*DW +: DW] : '0;

    // grant, accept and completion sequencing with the watchdog; owner keeps its value in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!act[owner]) begin
                        state <= IDLE;
                    end else if (ctrl_rdy) begin
                        state <= BUSY;
                        count <= '0;
                    end
                end
                BUSY: begin
                    if (any_done || wd_fire) begin
                        ptr   <= owner == IW'(N - 1) ? '0 : owner + 1'b1;
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
